// File: rtl/sd_spi_pkg.sv
// Shared FSM states, error codes and SD SPI byte constants for the command sequencer.
package sd_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_POLL_R1,
      ST_POLL_TOK,
      ST_DATA,
      ST_CRC,
      ST_TRAIL_GAP,
      ST_TRAIL
   } sd_state_t;

   localparam logic [1:0] ERR_OK     = 2'd0;
   localparam logic [1:0] ERR_R1_TO  = 2'd1;
   localparam logic [1:0] ERR_TOK_TO = 2'd2;
   localparam logic [1:0] ERR_TOK    = 2'd3;

   localparam logic [7:0] SD_IDLE_BYTE   = 8'hFF;
   localparam logic [7:0] SD_START_TOKEN = 8'hFE;
   localparam int         CMD_FRAME_LEN  = 6;

   // Byte idx of the 6-byte command frame: start/transmission bits, argument MSB first, CRC7 + end bit.
   function automatic logic [7:0] cmd_frame_byte(input logic [2:0]  idx,
                                                  input logic [5:0]  cmd_idx,
                                                  input logic [31:0] arg,
                                                  input logic [6:0]  crc);
      case (idx)
         3'd0:    cmd_frame_byte = {2'b01, cmd_idx};
         3'd1:    cmd_frame_byte = arg[31:24];
         3'd2:    cmd_frame_byte = arg[23:16];
         3'd3:    cmd_frame_byte = arg[15:8];
         3'd4:    cmd_frame_byte = arg[7:0];
         3'd5:    cmd_frame_byte = {crc, 1'b1};
         default: cmd_frame_byte = SD_IDLE_BYTE;
      endcase
   endfunction

endpackage

// File: rtl/sd_byte_port.sv
// Single-outstanding byte port to the SPI engine: send loads tx_byte/tx_valid next cycle, byte_done is rx_valid
// qualified by the outstanding byte (0 cycles); tx_valid and tx_byte hold for as long as tx_ready stays low.
module sd_byte_port
   import sd_spi_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       send,
   input  logic [7:0] send_byte,
   output logic       tx_valid,
   output logic [7:0] tx_byte,
   input  logic       tx_ready,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic       byte_done,
   output logic [7:0] done_byte
);

   logic outstanding;

   // rx_valid with nothing accepted and unfinished is not ours and is dropped here.
   assign byte_done = outstanding & rx_valid;
   assign done_byte = rx_byte;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_valid    <= 1'b0;
         tx_byte     <= SD_IDLE_BYTE;
         outstanding <= 1'b0;
      end else begin
         if (tx_valid && tx_ready) begin
            tx_valid    <= 1'b0;
            outstanding <= 1'b1;
         end else if (byte_done) begin
            outstanding <= 1'b0;
         end
         if (send) begin
            tx_valid <= 1'b1;
            tx_byte  <= send_byte;
         end
      end
   end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD SPI transaction sequencer: command frame, R1 poll, optional token + block + CRC, one trailing byte.
// First tx_valid 1 cycle after start, each next byte 1 cycle after rx_valid; waits indefinitely on tx_ready.
module sd_cmd_sequencer
   import sd_spi_pkg::*;
#(
   parameter int NCR_MAX   = 8,
   parameter int TOKEN_MAX = 2048,
   parameter int BLOCK_LEN = 512,
   parameter int CNT_W     = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  cmd_idx,
   input  logic [31:0] arg,
   input  logic [6:0]  crc,
   input  logic        expect_data,
   output logic        busy,
   output logic        done,
   output logic [7:0]  r1,
   output logic [1:0]  err,
   output logic        cs_n,
   output logic        tx_valid,
   output logic [7:0]  tx_byte,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   output logic        data_valid,
   output logic [7:0]  data_byte
);

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(CMD_FRAME_LEN);
   localparam logic [CNT_W-1:0] NCR_LAST  = CNT_W'(NCR_MAX - 1);
   localparam logic [CNT_W-1:0] TOK_LAST  = CNT_W'(TOKEN_MAX - 1);
   localparam logic [CNT_W-1:0] BLK_LAST  = CNT_W'(BLOCK_LEN - 1);

   sd_state_t        state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [5:0]       cmd_q, cmd_nx;
   logic [31:0]      arg_q, arg_nx;
   logic [6:0]       crc_q, crc_nx;
   logic             exp_q, exp_nx;
   logic             busy_nx, done_nx, cs_n_nx, dv_nx;
   logic [7:0]       r1_nx, db_nx;
   logic [1:0]       err_nx;
   logic             send, byte_done;
   logic [7:0]       send_byte, done_byte;

   sd_byte_port u_port (
      .clk       (clk),
      .rst       (rst),
      .send      (send),
      .send_byte (send_byte),
      .tx_valid  (tx_valid),
      .tx_byte   (tx_byte),
      .tx_ready  (tx_ready),
      .rx_valid  (rx_valid),
      .rx_byte   (rx_byte),
      .byte_done (byte_done),
      .done_byte (done_byte)
   );

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      cmd_nx    = cmd_q;
      arg_nx    = arg_q;
      crc_nx    = crc_q;
      exp_nx    = exp_q;
      busy_nx   = busy;
      done_nx   = 1'b0;
      cs_n_nx   = cs_n;
      r1_nx     = r1;
      err_nx    = err;
      dv_nx     = 1'b0;
      db_nx     = data_byte;
      send      = 1'b0;
      send_byte = SD_IDLE_BYTE;
      case (state)
         ST_IDLE: if (start) begin
            cmd_nx    = cmd_idx;
            arg_nx    = arg;
            crc_nx    = crc;
            exp_nx    = expect_data;
            err_nx    = ERR_OK;
            r1_nx     = SD_IDLE_BYTE;
            busy_nx   = 1'b1;
            cs_n_nx   = 1'b0;
            send      = 1'b1;
            send_byte = cmd_frame_byte(3'd0, cmd_idx, arg, crc);
            cnt_nx    = ONE;
            state_nx  = ST_SEND;
         end
         // In SEND, cnt counts frame bytes already handed to the port.
         ST_SEND: if (byte_done) begin
            send = 1'b1;
            if (cnt == FRAME_END) begin
               cnt_nx   = '0;
               state_nx = ST_POLL_R1;
            end else begin
               send_byte = cmd_frame_byte(cnt[2:0], cmd_q, arg_q, crc_q);
               cnt_nx    = cnt + ONE;
            end
         end
         ST_POLL_R1: if (byte_done) begin
            if (!done_byte[7]) begin
               r1_nx = done_byte;
               if (exp_q && done_byte == 8'h00) begin
                  send     = 1'b1;
                  cnt_nx   = '0;
                  state_nx = ST_POLL_TOK;
               end else begin
                  cs_n_nx  = 1'b1;
                  state_nx = ST_TRAIL_GAP;
               end
            end else if (cnt == NCR_LAST) begin
               err_nx   = ERR_R1_TO;
               cs_n_nx  = 1'b1;
               state_nx = ST_TRAIL_GAP;
            end else begin
               send   = 1'b1;
               cnt_nx = cnt + ONE;
            end
         end
         ST_POLL_TOK: if (byte_done) begin
            if (done_byte == SD_START_TOKEN) begin
               send     = 1'b1;
               cnt_nx   = '0;
               state_nx = ST_DATA;
            end else if (done_byte[7:4] == 4'h0) begin
               err_nx   = ERR_TOK;
               cs_n_nx  = 1'b1;
               state_nx = ST_TRAIL_GAP;
            end else if (cnt == TOK_LAST) begin
               err_nx   = ERR_TOK_TO;
               cs_n_nx  = 1'b1;
               state_nx = ST_TRAIL_GAP;
            end else begin
               send   = 1'b1;
               cnt_nx = cnt + ONE;
            end
         end
         ST_DATA: if (byte_done) begin
            dv_nx = 1'b1;
            db_nx = done_byte;
            send  = 1'b1;
            if (cnt == BLK_LAST) begin
               cnt_nx   = '0;
               state_nx = ST_CRC;
            end else begin
               cnt_nx = cnt + ONE;
            end
         end
         ST_CRC: if (byte_done) begin
            if (cnt == ONE) begin
               cs_n_nx  = 1'b1;
               state_nx = ST_TRAIL_GAP;
            end else begin
               send   = 1'b1;
               cnt_nx = cnt + ONE;
            end
         end
         // cs_n has been high for one cycle; the release byte goes out deselected.
         ST_TRAIL_GAP: begin
            send     = 1'b1;
            state_nx = ST_TRAIL;
         end
         ST_TRAIL: if (byte_done) begin
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         cmd_q      <= '0;
         arg_q      <= '0;
         crc_q      <= '0;
         exp_q      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cs_n       <= 1'b1;
         r1         <= SD_IDLE_BYTE;
         err        <= ERR_OK;
         data_valid <= 1'b0;
         data_byte  <= 8'h00;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         cmd_q      <= cmd_nx;
         arg_q      <= arg_nx;
         crc_q      <= crc_nx;
         exp_q      <= exp_nx;
         busy       <= busy_nx;
         done       <= done_nx;
         cs_n       <= cs_n_nx;
         r1         <= r1_nx;
         err        <= err_nx;
         data_valid <= dv_nx;
         data_byte  <= db_nx;
      end
   end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Scoreboard bench: an engine/card model answers every accepted byte, a transaction-level model predicts
// the tx stream, cs_n, block bytes and final r1/err; a negedge monitor pops and compares.
module tb_sd_cmd_sequencer;
   localparam int NCR_MAX   = 8;
   localparam int TOKEN_MAX = 2048;
   localparam int BLOCK_LEN = 512;

   logic        clk, rst, start, expect_data;
   logic [5:0]  cmd_idx;
   logic [31:0] arg;
   logic [6:0]  crc;
   logic        busy, done, cs_n, tx_valid, tx_ready, rx_valid, data_valid;
   logic [7:0]  r1, tx_byte, rx_byte, data_byte;
   logic [1:0]  err;

   sd_cmd_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .cmd_idx(cmd_idx), .arg(arg), .crc(crc),
      .expect_data(expect_data), .busy(busy), .done(done), .r1(r1), .err(err), .cs_n(cs_n),
      .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready), .rx_valid(rx_valid),
      .rx_byte(rx_byte), .data_valid(data_valid), .data_byte(data_byte)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] script_q[$];
   logic [7:0] resp_q[$];
   logic [7:0] exp_tx_q[$];
   logic       exp_cs_q[$];
   logic [7:0] exp_data_q[$];
   logic [9:0] exp_res_q[$];
   int         got_done, data_seen, tx_cnt;
   logic       stall_en, stall_done;
   logic [7:0] last_r1;
   logic [1:0] last_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event occurred, none expected", name);
   endtask

   function automatic logic [7:0] sbyte(input int i);
      if (i < script_q.size()) return script_q[i];
      return 8'hFF;
   endfunction

   task automatic push_tx(input logic [7:0] b, input logic cs);
      exp_tx_q.push_back(b);
      exp_cs_q.push_back(cs);
   endtask

   // Reference: walk the card's byte script with the protocol rules to predict everything the host side sees.
   task automatic model_txn(input logic [5:0] c, input logic [31:0] a, input logic [6:0] k, input logic e);
      int         i = 0;
      logic       got = 1'b0;
      logic [7:0] b;
      logic [7:0] r = 8'hFF;
      logic [1:0] er = 2'd0;
      push_tx(8'h40 + {2'b00, c}, 1'b0);
      push_tx(8'(a >> 24), 1'b0);
      push_tx(8'(a >> 16), 1'b0);
      push_tx(8'(a >> 8), 1'b0);
      push_tx(8'(a), 1'b0);
      push_tx(8'(k) * 8'd2 + 8'd1, 1'b0);
      resp_q.delete();
      repeat (6) resp_q.push_back(8'hFF);
      foreach (script_q[j]) resp_q.push_back(script_q[j]);
      for (int n = 0; n < NCR_MAX && !got; n++) begin
         b = sbyte(i); i++;
         push_tx(8'hFF, 1'b0);
         if (b < 8'h80) begin r = b; got = 1'b1; end
      end
      if (!got) er = 2'd1;
      else if (e && r == 8'h00) begin
         got = 1'b0;
         for (int n = 0; n < TOKEN_MAX && !got && er == 2'd0; n++) begin
            b = sbyte(i); i++;
            push_tx(8'hFF, 1'b0);
            if (b == 8'hFE) got = 1'b1;
            else if (b < 8'h10) er = 2'd3;
         end
         if (!got && er == 2'd0) er = 2'd2;
         if (got) begin
            for (int n = 0; n < BLOCK_LEN; n++) begin
               push_tx(8'hFF, 1'b0);
               exp_data_q.push_back(sbyte(i)); i++;
            end
            repeat (2) push_tx(8'hFF, 1'b0);
         end
      end
      push_tx(8'hFF, 1'b1);
      exp_res_q.push_back({r, er});
   endtask

   // SPI engine + card: random tx_ready, 1-3 cycle shifts, occasional stray rx_valid pulses.
   initial begin : engine
      logic acc;
      int   stall_left;
      stall_left = 0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_byte = 8'hFF;
      forever begin
         @(negedge clk);
         acc = tx_valid && tx_ready && !rst;
         @(posedge clk); #1;
         rx_valid = 1'b0;
         if (acc) begin
            tx_ready = 1'b0;
            tx_cnt++;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            rx_byte  = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hFF;
            rx_valid = 1'b1;
         end else begin
            if (stall_en && !stall_done && tx_valid && tx_cnt == 3) begin
               stall_left = 5;
               stall_done = 1'b1;
            end
            if (stall_left > 0) begin
               tx_ready = 1'b0;
               stall_left--;
            end else tx_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
               rx_byte  = 8'h00;
               rx_valid = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin : monitor
      logic       inflight, prev_hold;
      logic [7:0] prev_byte;
      logic [9:0] res;
      if (rst) begin
         inflight  = 1'b0;
         prev_hold = 1'b0;
      end else begin
         if (inflight) check("no_tx_while_outstanding", tx_valid, 1'b0);
         if (prev_hold) begin
            check("tx_valid_held", tx_valid, 1'b1);
            check("tx_byte_stable", tx_byte, prev_byte);
         end
         prev_hold = tx_valid && !tx_ready;
         prev_byte = tx_byte;
         if (rx_valid && inflight) inflight = 1'b0;
         if (tx_valid && tx_ready) begin
            inflight = 1'b1;
            if (exp_tx_q.size() == 0) flag("unexpected_tx_byte");
            else begin
               check("tx_byte", tx_byte, exp_tx_q.pop_front());
               check("cs_n_at_tx", cs_n, exp_cs_q.pop_front());
            end
         end
         if (data_valid) begin
            data_seen++;
            if (exp_data_q.size() == 0) flag("unexpected_data_valid");
            else check("data_byte", data_byte, exp_data_q.pop_front());
         end
         if (done) begin
            got_done++;
            if (exp_res_q.size() == 0) flag("unexpected_done");
            else begin
               res      = exp_res_q.pop_front();
               last_r1  = res[9:2];
               last_err = res[1:0];
               check("r1_at_done", r1, res[9:2]);
               check("err_at_done", err, res[1:0]);
               check("busy_low_at_done", busy, 1'b0);
            end
         end
      end
   end

   task automatic start_txn(input logic [5:0] c, input logic [31:0] a, input logic [6:0] k, input logic e);
      model_txn(c, a, k, e);
      got_done = 0; data_seen = 0; tx_cnt = 0; stall_done = 1'b0;
      @(posedge clk); #1;
      cmd_idx = c; arg = a; crc = k; expect_data = e; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("busy_after_start", busy, 1'b1);
      check("cs_n_after_start", cs_n, 1'b0);
      check("tx_valid_after_start", tx_valid, 1'b1);
      check("r1_cleared_at_start", r1, 8'hFF);
      check("err_cleared_at_start", err, 2'd0);
   endtask

   task automatic wait_done();
      int c = 0;
      while (got_done == 0 && c < 30000) begin @(negedge clk); c++; end
      if (got_done == 0) flag("done_timeout");
      check("tx_queue_drained", exp_tx_q.size(), 0);
      check("data_queue_drained", exp_data_q.size(), 0);
      repeat (3) @(negedge clk);
      check("done_single_pulse", got_done, 1);
      check("idle_busy", busy, 1'b0);
      check("idle_cs_n", cs_n, 1'b1);
      check("r1_held", r1, last_r1);
      check("err_held", err, last_err);
   endtask

   task automatic rand_script(input logic e);
      script_q.delete();
      repeat ($urandom_range(0, 9)) script_q.push_back(8'h80 | 8'($urandom));
      script_q.push_back((e && $urandom_range(0, 3) != 0) ? 8'h00 : (8'($urandom) & 8'h7F));
      repeat ($urandom_range(0, 4))
         script_q.push_back(($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(16, 253)));
      script_q.push_back(($urandom_range(0, 4) != 0) ? 8'hFE : 8'($urandom_range(0, 15)));
      repeat (BLOCK_LEN + 2) script_q.push_back(8'($urandom));
   endtask

   initial begin : stimulus
      logic e;
      rst = 1'b1; start = 1'b0; cmd_idx = '0; arg = '0; crc = '0; expect_data = 1'b0;
      stall_en = 1'b0; stall_done = 1'b0; got_done = 0; data_seen = 0; tx_cnt = 0;
      last_r1 = 8'hFF; last_err = 2'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_r1", r1, 8'hFF);
      check("rst_err", err, 2'd0);
      check("rst_cs_n", cs_n, 1'b1);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_tx_byte", tx_byte, 8'hFF);
      check("rst_data_valid", data_valid, 1'b0);
      check("rst_data_byte", data_byte, 8'h00);
      @(posedge clk); #1 rst = 1'b0;

      script_q = '{8'hFF, 8'hFF, 8'h01};
      start_txn(6'd0, 32'h0, 7'h4A, 1'b0);
      wait_done();

      script_q = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
      for (int i = 0; i < BLOCK_LEN; i++) script_q.push_back(8'(i));
      script_q.push_back(8'hA5); script_q.push_back(8'h5A);
      start_txn(6'd17, 32'h0000_0200, 7'h2B, 1'b1);
      wait_done();
      check("block_strobe_count", data_seen, BLOCK_LEN);

      script_q.delete();
      start_txn(6'd8, 32'h0000_01AA, 7'h43, 1'b0);
      wait_done();

      script_q = '{8'h00, 8'h09};
      start_txn(6'd17, 32'h0000_0400, 7'h11, 1'b1);
      wait_done();
      check("no_data_on_error_token", data_seen, 0);

      // Stall byte 3 and pulse start mid-transaction; the frame must be unaffected.
      stall_en = 1'b1;
      script_q = '{8'hFF, 8'h05};
      start_txn(6'd24, 32'h1234_5678, 7'h3C, 1'b0);
      repeat (4) @(posedge clk);
      #1 cmd_idx = 6'h3F; arg = 32'hDEAD_BEEF; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done();
      check("stall_applied", stall_done, 1'b1);
      stall_en = 1'b0;

      script_q = '{8'h00};
      start_txn(6'd17, 32'h0000_0600, 7'h22, 1'b1);
      wait_done();

      // Abort in the middle of the data block.
      rand_script(1'b1);
      script_q[0] = 8'h00;
      script_q[1] = 8'hFE;
      start_txn(6'd18, 32'h0000_0800, 7'h05, 1'b1);
      for (int c = 0; c < 5000 && data_seen < 16; c++) @(negedge clk);
      check("reached_data_phase", data_seen >= 16, 1'b1);
      @(posedge clk); #1 rst = 1'b1;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_cs_n", cs_n, 1'b1);
      check("abort_tx_valid", tx_valid, 1'b0);
      check("abort_r1", r1, 8'hFF);
      check("abort_data_valid", data_valid, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      exp_tx_q.delete(); exp_cs_q.delete(); exp_data_q.delete(); exp_res_q.delete(); resp_q.delete();
      rst = 1'b0;
      script_q = '{8'hFF, 8'h01};
      start_txn(6'd0, 32'h0, 7'h4A, 1'b0);
      wait_done();

      for (int t = 0; t < 6; t++) begin
         e = 1'($urandom_range(0, 1));
         rand_script(e);
         start_txn(6'($urandom), $urandom, 7'($urandom), e);
         wait_done();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
